branch_predictor: RTL and testbench

//   Fetch-stage direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.

---
 rtl/branch_predictor_if.sv | 34 +++
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Interface between the fetch/hazard logic and the branch predictor.
// Groups the lookup path, the resolved-branch update path and the
// statistics outputs. The master modport is the pipeline side, the slave
// modport is the predictor.
interface branch_predictor_if;
  // Lookup path
  logic [31:0] pc;
  logic        taken;
  logic [31:0] pred_target;
  logic        btb_hit;

  // Resolved-branch update path
  logic        br;
  logic        br_result;
  logic [31:0] br_pc;
  logic [31:0] braddr;
  logic        mispredict;
  logic        upd_en;
  logic        bp_clear;

  // Statistics
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  modport master (
    output pc, br, br_result, br_pc, braddr, mispredict, upd_en, bp_clear,
    input  taken, pred_target, btb_hit, br_count, mispred_count
  );

  modport slave (
    input  pc, br, br_result, br_pc, braddr, mispredict, upd_en, bp_clear,
    output taken, pred_target, btb_hit, br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped branch target buffer with a 2-bit saturating
// counter per entry. Lookup is combinational; updates from the hazard unit
// commit on the clock edge. Also counts resolved branches and mispredicts.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input logic              CLK,
  input logic              nRST,
  branch_predictor_if.slave bus
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic [31:0] br_cnt_q;
  logic [31:0] misp_cnt_q;

  logic [IDXW-1:0] lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic            lk_taken;

  logic [IDXW-1:0] up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;
  logic            upd;

  assign lk_idx = bus.pc[IDXW+1:2];
  assign lk_tag = bus.pc[31:IDXW+2];
  assign up_idx = bus.br_pc[IDXW+1:2];
  assign up_tag = bus.br_pc[31:IDXW+2];
  assign upd    = bus.br && bus.upd_en;

  // Lookup: hit/taken/target from the current (pre-update) table contents
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    lk_hit   = 1'b0;
    lk_taken = 1'b0;
    if (valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
      lk_hit   = 1'b1;
      lk_taken = ctr_q[lk_idx][1];
    end
  end

  assign bus.btb_hit     = lk_hit;
  assign bus.taken       = lk_taken;
  assign bus.pred_target = lk_taken ? target_q[lk_idx] : bus.pc + 32'd4;

  // Hit detection for the resolved branch being reported
  always_comb begin
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  // Table update: clear beats any update; hits train, taken misses allocate
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the whole table is reset here because reset must also zero tag/target/ctr, not just valid.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_SNT;
      end
    end else if (bus.bp_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd) begin
      if (up_hit) begin
        if (bus.br_result) begin
          ctr_q[up_idx]    <= (ctr_q[up_idx] == CTR_ST) ? CTR_ST : ctr_q[up_idx] + 2'd1;
          target_q[up_idx] <= bus.braddr;
        end else begin
          ctr_q[up_idx] <= (ctr_q[up_idx] == CTR_SNT) ? CTR_SNT : ctr_q[up_idx] - 2'd1;
        end
      end else if (bus.br_result) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.braddr;
        ctr_q[up_idx]    <= CTR_WT;
      end
    end
  end

  // Statistics: saturating counts of qualified branch reports and mispredicts
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else if (upd) begin
      if (br_cnt_q != '1) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (bus.mispredict && (misp_cnt_q != '1)) begin
        misp_cnt_q <= misp_cnt_q + 32'd1;
      end
    end
  end

  assign bus.br_count      = br_cnt_q;
  assign bus.mispred_count = misp_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (ENTRIES=16).
module tb_branch_predictor;

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_fail;

  branch_predictor_if bus ();

  branch_predictor #(.ENTRIES(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Present one branch report at the falling edge, let it commit at the
  // rising edge, then drop br shortly after.
  task automatic drive(input logic [31:0] a, input logic res, input logic [31:0] tgt,
                       input logic misp, input logic brv, input logic en, input logic clr);
    @(negedge CLK);
    bus.br         = brv;
    bus.upd_en     = en;
    bus.br_pc      = a;
    bus.br_result  = res;
    bus.braddr     = tgt;
    bus.mispredict = misp;
    bus.bp_clear   = clr;
    @(posedge CLK);
    #1;
    bus.br         = 1'b0;
    bus.mispredict = 1'b0;
    bus.bp_clear   = 1'b0;
    bus.upd_en     = 1'b1;
  endtask

  task automatic look(input logic [31:0] a);
    bus.pc = a;
    #1;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    bus.pc = 32'h40; bus.br = 0; bus.br_result = 0; bus.br_pc = 0; bus.braddr = 0;
    bus.mispredict = 0; bus.upd_en = 1; bus.bp_clear = 0;
    #1;
    n_checks++;
    if ({bus.btb_hit, bus.taken, bus.pred_target} !== {1'b0, 1'b0, 32'h44}) begin
      n_fail++;
      $display("FAIL reset_lookup: got hit=%b taken=%b target=%h, want 0 0 00000044", bus.btb_hit, bus.taken, bus.pred_target);
    end
    n_checks++;
    if ({bus.br_count, bus.mispred_count} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got %h/%h, want 0/0", bus.br_count, bus.mispred_count);
    end
    look(32'hFFFF_FFFC);
    n_checks++;
    if (bus.pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h, want 00000000", bus.pred_target);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_alloc;
    // Same-cycle lookup sees pre-update contents (no bypass)
    @(negedge CLK);
    bus.br = 1; bus.upd_en = 1; bus.br_pc = 32'h40; bus.br_result = 1; bus.braddr = 32'h100;
    bus.pc = 32'h40;
    #1;
    n_checks++;
    if (bus.btb_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass: got hit=%b, want 0", bus.btb_hit);
    end
    @(posedge CLK);
    #1;
    bus.br = 0;
    look(32'h40);
    n_checks++;
    if ({bus.btb_hit, bus.taken, bus.pred_target} !== {1'b1, 1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL alloc_lookup: got hit=%b taken=%b target=%h, want 1 1 00000100", bus.btb_hit, bus.taken, bus.pred_target);
    end
    n_checks++;
    if (bus.br_count !== 32'd1) begin
      n_fail++;
      $display("FAIL alloc_br_count: got %0d, want 1", bus.br_count);
    end
  endtask

  task automatic test_counter;
    drive(32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);  // 10 -> 01
    look(32'h40);
    n_checks++;
    if ({bus.btb_hit, bus.taken, bus.pred_target} !== {1'b1, 1'b0, 32'h44}) begin
      n_fail++;
      $display("FAIL ctr_weak_nt: got hit=%b taken=%b target=%h, want 1 0 00000044", bus.btb_hit, bus.taken, bus.pred_target);
    end
    for (int i = 0; i < 3; i++) drive(32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);  // 00, 00, 00
    drive(32'h40, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0);  // 00 -> 01
    look(32'h40);
    n_checks++;
    if ({bus.btb_hit, bus.taken, bus.pred_target} !== {1'b1, 1'b0, 32'h44}) begin
      n_fail++;
      $display("FAIL ctr_sat_low: got hit=%b taken=%b target=%h, want 1 0 00000044", bus.btb_hit, bus.taken, bus.pred_target);
    end
    drive(32'h40, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0);  // 01 -> 10
    look(32'h40);
    n_checks++;
    if ({bus.taken, bus.pred_target} !== {1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL ctr_weak_t: got taken=%b target=%h, want 1 00000200", bus.taken, bus.pred_target);
    end
    drive(32'h40, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0);  // 10 -> 11
    drive(32'h40, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0);  // 11 stays
    drive(32'h40, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0);  // 11 -> 10
    look(32'h40);
    n_checks++;
    if ({bus.taken, bus.pred_target} !== {1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL ctr_sat_high: got taken=%b target=%h, want 1 00000200", bus.taken, bus.pred_target);
    end
    n_checks++;
    if (bus.br_count !== 32'd10) begin
      n_fail++;
      $display("FAIL ctr_br_count: got %0d, want 10", bus.br_count);
    end
  endtask

  task automatic test_miss_not_taken;
    drive(32'h300, 1'b0, 32'h900, 1'b0, 1'b1, 1'b1, 1'b0);
    look(32'h300);
    n_checks++;
    if ({bus.btb_hit, bus.pred_target} !== {1'b0, 32'h304}) begin
      n_fail++;
      $display("FAIL miss_nt_no_alloc: got hit=%b target=%h, want 0 00000304", bus.btb_hit, bus.pred_target);
    end
  endtask

  task automatic test_conflict;
    drive(32'h40, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(32'h80, 1'b1, 32'h180, 1'b0, 1'b1, 1'b1, 1'b0);
    look(32'h40);
    n_checks++;
    if ({bus.btb_hit, bus.taken, bus.pred_target} !== {1'b0, 1'b0, 32'h44}) begin
      n_fail++;
      $display("FAIL conflict_evicted: got hit=%b taken=%b target=%h, want 0 0 00000044", bus.btb_hit, bus.taken, bus.pred_target);
    end
    look(32'h80);
    n_checks++;
    if ({bus.btb_hit, bus.taken, bus.pred_target} !== {1'b1, 1'b1, 32'h180}) begin
      n_fail++;
      $display("FAIL conflict_new: got hit=%b taken=%b target=%h, want 1 1 00000180", bus.btb_hit, bus.taken, bus.pred_target);
    end
  endtask

  task automatic test_upd_en;
    drive(32'h500, 1'b1, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0);  // upd_en=0
    drive(32'h500, 1'b1, 32'h600, 1'b1, 1'b0, 1'b1, 1'b0);  // br=0
    look(32'h500);
    n_checks++;
    if (bus.btb_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL unqualified_table: got hit=%b, want 0", bus.btb_hit);
    end
    n_checks++;
    if ({bus.br_count, bus.mispred_count} !== {32'd13, 32'd0}) begin
      n_fail++;
      $display("FAIL unqualified_counts: got %0d/%0d, want 13/0", bus.br_count, bus.mispred_count);
    end
    drive(32'h80, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);  // 10 -> 01, mispredict
    n_checks++;
    if ({bus.br_count, bus.mispred_count} !== {32'd14, 32'd1}) begin
      n_fail++;
      $display("FAIL mispred_counts: got %0d/%0d, want 14/1", bus.br_count, bus.mispred_count);
    end
    look(32'h80);
    n_checks++;
    if ({bus.btb_hit, bus.taken, bus.pred_target} !== {1'b1, 1'b0, 32'h84}) begin
      n_fail++;
      $display("FAIL mispred_train: got hit=%b taken=%b target=%h, want 1 0 00000084", bus.btb_hit, bus.taken, bus.pred_target);
    end
  endtask

  task automatic test_clear;
    drive(32'h44, 1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 1'b0);
    look(32'h44);
    n_checks++;
    if ({bus.btb_hit, bus.pred_target} !== {1'b1, 32'h400}) begin
      n_fail++;
      $display("FAIL pre_clear: got hit=%b target=%h, want 1 00000400", bus.btb_hit, bus.pred_target);
    end
    drive(32'h48, 1'b1, 32'h800, 1'b0, 1'b1, 1'b1, 1'b1);  // clear + taken update
    for (int i = 0; i < 3; i++) begin
      look(32'h44 + 32'(i) * 32'h4 - ((i == 0) ? 32'h0 : 32'h0));
      n_checks++;
      if (bus.btb_hit !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_entry: pc=%h got hit=%b, want 0", bus.pc, bus.btb_hit);
      end
    end
    look(32'h80);
    n_checks++;
    if (bus.btb_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_entry_80: got hit=%b, want 0", bus.btb_hit);
    end
    n_checks++;
    if ({bus.br_count, bus.mispred_count} !== {32'd16, 32'd1}) begin
      n_fail++;
      $display("FAIL clear_counts: got %0d/%0d, want 16/1", bus.br_count, bus.mispred_count);
    end
  endtask

  task automatic test_saturation;
    @(negedge CLK);
    force dut.br_cnt_q = 32'hFFFF_FFFE;
    force dut.misp_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_cnt_q;
    release dut.misp_cnt_q;
    drive(32'h40, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({bus.br_count, bus.mispred_count} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL sat_reach: got %h/%h, want ffffffff/ffffffff", bus.br_count, bus.mispred_count);
    end
    drive(32'h40, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({bus.br_count, bus.mispred_count} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL sat_hold: got %h/%h, want ffffffff/ffffffff", bus.br_count, bus.mispred_count);
    end
  endtask

  task automatic test_reset_mid_burst;
    @(negedge CLK);
    bus.br = 1; bus.upd_en = 1; bus.br_pc = 32'h44; bus.br_result = 1; bus.braddr = 32'h700;
    bus.mispredict = 1;
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    bus.pc = 32'h40;
    #1;
    n_checks++;
    if ({bus.btb_hit, bus.taken, bus.pred_target} !== {1'b0, 1'b0, 32'h44}) begin
      n_fail++;
      $display("FAIL mid_reset_lookup: got hit=%b taken=%b target=%h, want 0 0 00000044", bus.btb_hit, bus.taken, bus.pred_target);
    end
    n_checks++;
    if ({bus.br_count, bus.mispred_count} !== 64'd0) begin
      n_fail++;
      $display("FAIL mid_reset_counts: got %h/%h, want 0/0", bus.br_count, bus.mispred_count);
    end
    @(posedge CLK);
    #1;
    bus.br = 0;
    bus.mispredict = 0;
    @(negedge CLK);
    nRST = 1'b1;
    look(32'h44);
    n_checks++;
    if ({bus.btb_hit, bus.pred_target, bus.br_count} !== {1'b0, 32'h48, 32'd0}) begin
      n_fail++;
      $display("FAIL post_reset: got hit=%b target=%h br_count=%0d, want 0 00000048 0", bus.btb_hit, bus.pred_target, bus.br_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_alloc();
    test_counter();
    test_miss_not_taken();
    test_conflict();
    test_upd_en();
    test_clear();
    test_saturation();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
